// File: rtl/intersection_controller.sv
// rtl/intersection_controller.sv - two-road traffic light scheduler with pedestrian phase
//
// Purpose : Moore state machine sequencing main-road (NS), side-road (EW) and
//           pedestrian lamps from one shared phase counter clocked by `tick`.
//           Conflicting greens are always separated by an all-red phase.
// Ports   : clock, reset (sync, active-high), tick (timebase strobe),
//           car_ew (side-road sensor), ped_req (walk button),
//           flash (only with FLASH_MODE_EN),
//           ns_red/ns_amber/ns_green, ew_red/ew_amber/ew_green, walk,
//           ped_ack (first clock of walk), phase[2:0] (state, debug).
// Option  : FLASH_MODE_EN adds the `flash` input and the FLASH state (7).
module intersection_controller #(
   parameter int GREEN_TICS  = 200,
   parameter int AMBER_TICS  = 30,
   parameter int ALLRED_TICS = 4,
   parameter int PED_TICS    = 50,
   parameter int CNT_W       = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       tick,
   input  logic       car_ew,
   input  logic       ped_req,
`ifdef FLASH_MODE_EN
   input  logic       flash,
`endif
   output logic       ns_red,
   output logic       ns_amber,
   output logic       ns_green,
   output logic       ew_red,
   output logic       ew_amber,
   output logic       ew_green,
   output logic       walk,
   output logic       ped_ack,
   output logic [2:0] phase
);

   typedef enum logic [2:0] {
      S_NS_GREEN = 3'd0,
      S_NS_AMBER = 3'd1,
      S_ALLRED_A = 3'd2,
      S_EW_GREEN = 3'd3,
      S_EW_AMBER = 3'd4,
      S_ALLRED_B = 3'd5,
      S_PED_WALK = 3'd6
`ifdef FLASH_MODE_EN
      ,S_FLASH   = 3'd7
`endif
   } state_t;

   // Counter reload value for a phase: a phase lasts exactly N ticks when
   // loaded with N-1 and expiring on the tick that finds the counter at 0.
   function automatic logic [CNT_W-1:0] load_of(input state_t s);
      case (s)
         S_NS_GREEN, S_EW_GREEN: load_of = CNT_W'(GREEN_TICS - 1);
         S_NS_AMBER, S_EW_AMBER: load_of = CNT_W'(AMBER_TICS - 1);
         S_ALLRED_A, S_ALLRED_B: load_of = CNT_W'(ALLRED_TICS - 1);
         S_PED_WALK:             load_of = CNT_W'(PED_TICS - 1);
         default:                load_of = '0;
      endcase
   endfunction

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ew_pend_q, ew_pend_d;
   logic             ped_pend_q, ped_pend_d;
   logic             expire;

   logic ns_red_q, ns_amber_q, ns_green_q;
   logic ew_red_q, ew_amber_q, ew_green_q;
   logic walk_q, ped_ack_q;
   logic [2:0] phase_q;

`ifdef FLASH_MODE_EN
   logic flash_amb_q, flash_amb_d;
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ew_pend_d  = ew_pend_q | car_ew;
      ped_pend_d = ped_pend_q | ped_req;
      expire     = tick && (cnt_q == '0);
`ifdef FLASH_MODE_EN
      flash_amb_d = flash_amb_q;
`endif

      if (tick && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end

      // Decisions use the registered pending flags; NS_GREEN with nothing
      // pending simply re-expires on every tick with the counter parked at 0.
      if (expire) begin
         case (state_q)
            S_NS_GREEN: if (ew_pend_q || ped_pend_q) state_d = S_NS_AMBER;
            S_NS_AMBER: state_d = S_ALLRED_A;
            S_ALLRED_A: state_d = ew_pend_q ? S_EW_GREEN : S_PED_WALK;
            S_EW_GREEN: state_d = S_EW_AMBER;
            S_EW_AMBER: state_d = S_ALLRED_B;
            S_ALLRED_B: state_d = ped_pend_q ? S_PED_WALK : S_NS_GREEN;
            S_PED_WALK: state_d = S_NS_GREEN;
            default:    state_d = state_q;
         endcase
      end

`ifdef FLASH_MODE_EN
      if (flash) begin
         state_d = S_FLASH;
         // Ambers start lit on entry, then toggle on each tick while flashing.
         if (state_q != S_FLASH) begin
            flash_amb_d = 1'b1;
         end else if (tick) begin
            flash_amb_d = ~flash_amb_q;
         end
      end else if (state_q == S_FLASH) begin
         state_d = S_ALLRED_B;
      end
`endif

      if (state_d != state_q) begin
         cnt_d = load_of(state_d);
      end

      // Granting a phase absorbs any request arriving on the same clock.
      if ((state_d == S_EW_GREEN) && (state_q != S_EW_GREEN)) begin
         ew_pend_d = 1'b0;
      end
      if ((state_d == S_PED_WALK) && (state_q != S_PED_WALK)) begin
         ped_pend_d = 1'b0;
      end
   end

   // Single sequential block: state, counter, flags and registered lamp
   // decode of the next state (so lamps always match the state register).
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= S_ALLRED_B;
         cnt_q      <= load_of(S_ALLRED_B);
         ew_pend_q  <= 1'b0;
         ped_pend_q <= 1'b0;
         ns_red_q   <= 1'b1;
         ns_amber_q <= 1'b0;
         ns_green_q <= 1'b0;
         ew_red_q   <= 1'b1;
         ew_amber_q <= 1'b0;
         ew_green_q <= 1'b0;
         walk_q     <= 1'b0;
         ped_ack_q  <= 1'b0;
         phase_q    <= 3'd5;
`ifdef FLASH_MODE_EN
         flash_amb_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ew_pend_q  <= ew_pend_d;
         ped_pend_q <= ped_pend_d;
         ns_green_q <= (state_d == S_NS_GREEN);
         ew_green_q <= (state_d == S_EW_GREEN);
         walk_q     <= (state_d == S_PED_WALK);
         ped_ack_q  <= (state_d == S_PED_WALK) && (state_q != S_PED_WALK);
         phase_q    <= state_d;
`ifdef FLASH_MODE_EN
         flash_amb_q <= flash_amb_d;
         ns_amber_q  <= (state_d == S_NS_AMBER) || ((state_d == S_FLASH) && flash_amb_d);
         ew_amber_q  <= (state_d == S_EW_AMBER) || ((state_d == S_FLASH) && flash_amb_d);
         ns_red_q    <= !((state_d == S_NS_GREEN) || (state_d == S_NS_AMBER) || (state_d == S_FLASH));
         ew_red_q    <= !((state_d == S_EW_GREEN) || (state_d == S_EW_AMBER) || (state_d == S_FLASH));
`else
         ns_amber_q  <= (state_d == S_NS_AMBER);
         ew_amber_q  <= (state_d == S_EW_AMBER);
         ns_red_q    <= !((state_d == S_NS_GREEN) || (state_d == S_NS_AMBER));
         ew_red_q    <= !((state_d == S_EW_GREEN) || (state_d == S_EW_AMBER));
`endif
      end
   end

   assign ns_red   = ns_red_q;
   assign ns_amber = ns_amber_q;
   assign ns_green = ns_green_q;
   assign ew_red   = ew_red_q;
   assign ew_amber = ew_amber_q;
   assign ew_green = ew_green_q;
   assign walk     = walk_q;
   assign ped_ack  = ped_ack_q;
   assign phase    = phase_q;

endmodule

// File: tb/tb_intersection_controller.sv
// tb/tb_intersection_controller.sv - scoreboard bench for intersection_controller
module tb_intersection_controller;

   logic clock = 1'b0;
   logic reset, tick, car_ew, ped_req;
   logic ns_red, ns_amber, ns_green, ew_red, ew_amber, ew_green, walk, ped_ack;
   logic [2:0] phase;
`ifdef FLASH_MODE_EN
   logic flash = 1'b0;
`endif

   always #5 clock = ~clock;

   intersection_controller #(
      .GREEN_TICS(4), .AMBER_TICS(2), .ALLRED_TICS(1), .PED_TICS(3), .CNT_W(8)
   ) dut (
      .clock(clock), .reset(reset), .tick(tick), .car_ew(car_ew), .ped_req(ped_req),
`ifdef FLASH_MODE_EN
      .flash(flash),
`endif
      .ns_red(ns_red), .ns_amber(ns_amber), .ns_green(ns_green),
      .ew_red(ew_red), .ew_amber(ew_amber), .ew_green(ew_green),
      .walk(walk), .ped_ack(ped_ack), .phase(phase)
   );

   // Reference model: phase index, ticks still to serve in it, request latches.
   int dur [7] = '{4, 2, 1, 4, 2, 1, 3};
   int m_ph, m_left;
   bit m_ew, m_ped, m_ack;

   logic [10:0] exp_q [$];
   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;

   function automatic logic [10:0] expected_vec();
      logic ng, na, eg, ea;
      ng = (m_ph == 0); na = (m_ph == 1);
      eg = (m_ph == 3); ea = (m_ph == 4);
      return {3'(m_ph), !(ng || na), na, ng, !(eg || ea), ea, eg, (m_ph == 6), m_ack};
   endfunction

   task automatic model_step(input bit rst, input bit tk, input bit car, input bit ped);
      int nph;
      if (rst) begin
         m_ph = 5; m_left = 1; m_ew = 0; m_ped = 0; m_ack = 0;
         return;
      end
      nph = m_ph;
      if (tk) begin
         if (m_left > 1) m_left--;
         else begin
            case (m_ph)
               0: nph = (m_ew || m_ped) ? 1 : 0;
               1: nph = 2;
               2: nph = m_ew ? 3 : 6;
               3: nph = 4;
               4: nph = 5;
               5: nph = m_ped ? 6 : 0;
               default: nph = 0;
            endcase
         end
      end
      m_ack = (nph != m_ph) && (nph == 6);
      if (nph != m_ph) m_left = dur[nph];
      m_ew  = (m_ew || car) && !(nph == 3 && m_ph != 3);
      m_ped = (m_ped || ped) && !(nph == 6 && m_ph != 6);
      m_ph = nph;
   endtask

   task automatic drive(input bit rst, input bit tk, input bit car, input bit ped);
      @(negedge clock);
      reset = rst; tick = tk; car_ew = car; ped_req = ped;
      model_step(rst, tk, car, ped);
      exp_q.push_back(expected_vec());
   endtask

   // Monitor: every clock the DUT presents a full lamp vector; compare it.
   initial begin
      logic [10:0] got, want;
      forever begin
         @(posedge clock);
         #1;
         cyc++;
         if (exp_q.size() != 0) begin
            want = exp_q.pop_front();
            got = {phase, ns_red, ns_amber, ns_green, ew_red, ew_amber, ew_green, walk, ped_ack};
            n_cmp++;
            if (got !== want) begin
               n_err++;
               $display("FAIL lamps cyc=%0d got=%b want=%b (phase,nsR,nsA,nsG,ewR,ewA,ewG,walk,ack)",
                        cyc, got, want);
            end
            n_cmp++;
            if ((ns_green || ns_amber) && (ew_green || ew_amber)) begin
               n_err++;
               $display("FAIL safety cyc=%0d got ns_ga=%b ew_ga=%b want not both",
                        cyc, {ns_green, ns_amber}, {ew_green, ew_amber});
            end
         end
      end
   end

   initial begin
      reset = 1'b1; tick = 1'b0; car_ew = 1'b0; ped_req = 1'b0;
      // Reset then idle: ALLRED_B one clock, NS_GREEN held.
      repeat (3) drive(1, 1, 0, 0);
      repeat (100) drive(0, 1, 0, 0);
      // Single car pulse after NS_GREEN expiry, then full EW cycle.
      drive(0, 1, 1, 0);
      repeat (20) drive(0, 1, 0, 0);
      // Car and pedestrian both pending.
      drive(0, 1, 1, 1);
      repeat (25) drive(0, 1, 0, 0);
      // Tick every 4th clock with a side-road request.
      for (int i = 0; i < 160; i++) drive(0, (i % 4) == 3, i == 10, i == 70);
      // Reset landing mid-EW_GREEN.
      drive(0, 1, 1, 0);
      repeat (4) drive(0, 1, 0, 0);
      drive(1, 1, 1, 1);
      repeat (10) drive(0, 1, 0, 0);
      // Randomised traffic with occasional resets and sparse ticks.
      for (int i = 0; i < 3000; i++)
         drive($urandom_range(0, 299) == 0, $urandom_range(0, 2) != 0,
               $urandom_range(0, 19) == 0, $urandom_range(0, 24) == 0);
      repeat (3) @(posedge clock);
      #2;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain got=%0d pending want=0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/intersection_controller.md
Name: intersection_controller

Overview:
Sequences the vehicle and pedestrian lights of a two-road crossing (north-south main road, east-west side road) from one Moore state machine and a shared phase timer. Phase durations are counted in `tick` strobes from an external prescaler, so the block runs on the fast system clock. It arbitrates between side-road car demand and pedestrian demand, and guarantees an all-red clearance between conflicting greens. It replaces free-running per-light timing tasks with a synthesizable scheduler.

Parameters:
- GREEN_TICS, 200, minimum ticks in NS_GREEN; exact ticks in EW_GREEN.
- AMBER_TICS, 30, ticks in each amber phase.
- ALLRED_TICS, 4, ticks in each all-red clearance.
- PED_TICS, 50, ticks in the pedestrian walk phase.
- CNT_W, 16, phase counter width. Every *_TICS value is ≥1 and ≤2^CNT_W.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- tick  in  1  timebase strobe, one clock wide.
- car_ew  in  1  side-road car sensor, level.
- ped_req  in  1  pedestrian button, level or pulse.
- ns_red, ns_amber, ns_green  out  1 each  main-road lamps.
- ew_red, ew_amber, ew_green  out  1 each  side-road lamps.
- walk  out  1  pedestrian walk lamp.
- ped_ack  out  1  one-clock pulse when a walk phase is granted.
- phase  out  3  current state encoding, for debug.

Behaviour:
- States and encoding: NS_GREEN=0, NS_AMBER=1, ALLRED_A=2, EW_GREEN=3, EW_AMBER=4, ALLRED_B=5, PED_WALK=6.
- Outputs are a pure decode of the state register:
  - Each road shows exactly one lamp.
  - A road is red unless it is in its own green or amber state.
  - `walk`=1 only in PED_WALK.
- Phase counter:
  - On entry to a state, the counter loads that state's TICS−1.
  - It decrements on each clock where `tick`=1 and the counter is >0.
  - The phase expires on a clock where `tick`=1 and the counter is 0.
  - A phase therefore lasts exactly N ticks.
- Transitions, taken only on expiry:
  - NS_GREEN→NS_AMBER only if ew_pending or ped_pending. Otherwise it holds NS_GREEN with the counter at 0, and leaves on the first tick after a pending flag rises.
  - NS_AMBER→ALLRED_A.
  - ALLRED_A→EW_GREEN if ew_pending, else →PED_WALK.
  - EW_GREEN→EW_AMBER→ALLRED_B.
  - ALLRED_B→PED_WALK if ped_pending, else →NS_GREEN.
  - PED_WALK→NS_GREEN.
- Pending flags:
  - ew_pending is set on any clock with car_ew=1.
  - ped_pending is set on any clock with ped_req=1.
  - Each is cleared on the clock that enters EW_GREEN or PED_WALK respectively.
  - If the request and the clear fall on the same clock, the clear wins: the request is absorbed by the phase being granted.
- `ped_ack` is high for exactly the first clock in PED_WALK.
- Reset, from any state at any point:
  - state=ALLRED_B, counter=ALLRED_TICS−1, both pending flags cleared.
  - Outputs: ns_red=ew_red=1, all other lamps 0, walk=0, ped_ack=0, phase=5.
  - Reset takes priority over `tick`.
- Safety invariant: ns_green|ns_amber and ew_green|ew_amber are never both 1. There is at least one ALLRED state between any two conflicting greens.
- `tick` held high continuously is legal: the timer then counts clocks.

Optional Feature:
FLASH_MODE_EN. When defined:
- Adds input port `flash` (1 bit) and state FLASH=7.
- `flash`=1 forces FLASH on the next clock from any state, with priority below reset.
- In FLASH: all reds and greens are 0, walk=0, and ns_amber=ew_amber toggles on every tick, starting at 1.
- On `flash`=0, the next state is ALLRED_B with a full ALLRED_TICS load. Pending flags keep latching throughout FLASH.

When undefined: no `flash` port, no FLASH state, and `phase` value 7 is unreachable.

Test Plan:
All scenarios use GREEN=4, AMBER=2, ALLRED=1, PED=3, with `tick` tied to 1 except where stated.
- Reset, then no requests: phase 5 for 1 clock, then NS_GREEN held indefinitely; ns_green=1 and ew_red=1 after 100 clocks.
- car_ew pulsed 1 clock while in NS_GREEN after expiry: next clock NS_AMBER for 2, ALLRED_A 1, EW_GREEN 4, EW_AMBER 2, ALLRED_B 1, then NS_GREEN.
- ped_req and car_ew both pending in NS_GREEN: sequence through EW phases, then ALLRED_B→PED_WALK. walk=1 for 3 clocks, ped_ack high only on the first of them, then NS_GREEN.
- `tick` every 4th clock: NS_AMBER lasts exactly 8 clocks, measured from entry to the next state.
- reset asserted mid-EW_GREEN: next clock phase=5, ew_green=0, ew_red=1, pending flags 0.
- With FLASH_MODE_EN: `flash`=1 during EW_GREEN gives phase=7 and ambers toggling 1,0,1. Releasing `flash` gives ALLRED_B for 1 tick, then NS_GREEN, or PED_WALK if ped_req was pressed during flash.
